// File: rtl/board_shuffler.sv
// Board generator: emits an identity or Fisher-Yates shuffled tile board with a fixed blank cell.
// Optional macro BOARD_PARITY_FIX_EN forces every board to an even permutation (solvable).
module board_shuffler #(
    parameter int unsigned   CELLS     = 4,
    parameter int unsigned   CW        = 3,
    parameter logic [CW-1:0] BLANK     = 3'b100,
    parameter int unsigned   BLANK_POS = 1
) (
    input  logic                  clk_d,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode_rand,
    input  logic                  seed_load,
    input  logic [15:0]           seed,
    output logic                  busy,
    output logic                  done,
    output logic [CELLS*CW-1:0]   board
);

    localparam int unsigned TN        = CELLS - 1;
    localparam int unsigned IW        = (CELLS > 2) ? $clog2(CELLS - 1) : 1;
    localparam int unsigned LAST      = TN - 1;
    localparam int unsigned PREV      = (TN >= 2) ? TN - 2 : 0;
    localparam logic [15:0] LFSR_INIT = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef logic [TN-1:0][CW-1:0]    tiles_t;
    typedef logic [CELLS-1:0][CW-1:0] board_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SHUFFLE,
        S_FIX,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    tiles_t        r_t;
    tiles_t        w_t_swap;
    tiles_t        w_t_fix;
    board_t        r_board;
    logic [IW-1:0] r_i;
    logic [IW-1:0] w_j;
    logic [15:0]   r_lfsr;
    logic [15:0]   w_lfsr_adv;
    logic          r_mode;
    logic          r_busy;
    logic          r_done;

    function automatic tiles_t identity_tiles();
        tiles_t t;
        for (int unsigned k = 0; k < TN; k++) begin
            t[k] = CW'(k);
        end
        return t;
    endfunction

    // Tiles fill the non-blank cells in ascending order.
    function automatic board_t layout(input tiles_t t);
        board_t b;
        b = {CELLS{BLANK}};
        for (int unsigned k = 0; k < TN; k++) begin
            if (k < BLANK_POS) begin
                b[k] = t[k];
            end else begin
                b[k+1] = t[k];
            end
        end
        return b;
    endfunction

    // State register
    always_ff @(posedge clk_d or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_INIT;
                end
            end
            S_INIT: begin
                w_state_nxt = (r_mode && (CELLS > 2)) ? S_SHUFFLE : S_FIX;
            end
            S_SHUFFLE: begin
                if (r_i == IW'(1)) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX:   w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_lfsr_adv = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);

    // Fisher-Yates step: j drawn from the low LFSR byte, reduced into 0..i
    assign w_j = IW'(r_lfsr[7:0] % (8'(r_i) + 8'd1));

    always_comb begin
        w_t_swap        = r_t;
        w_t_swap[r_i]   = r_t[w_j];
        w_t_swap[w_j]   = r_t[r_i];
    end

`ifdef BOARD_PARITY_FIX_EN
    logic w_odd;

    // An odd inversion count is corrected by swapping the two highest tile slots.
    always_comb begin
        w_odd = 1'b0;
        for (int unsigned a = 0; a < TN; a++) begin
            for (int unsigned b = a + 1; b < TN; b++) begin
                if (r_t[a] > r_t[b]) begin
                    w_odd = ~w_odd;
                end
            end
        end
        w_t_fix = r_t;
        if ((CELLS >= 3) && w_odd) begin
            w_t_fix[LAST] = r_t[PREV];
            w_t_fix[PREV] = r_t[LAST];
        end
    end
`else
    assign w_t_fix = r_t;
`endif

    // Datapath and registered outputs
    always_ff @(posedge clk_d or posedge rst) begin
        if (rst) begin
            r_t     <= identity_tiles();
            r_i     <= '0;
            r_mode  <= 1'b0;
            r_board <= {CELLS{BLANK}};
            r_lfsr  <= LFSR_INIT;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (w_state_nxt == S_DONE);

            if (seed_load) begin
                r_lfsr <= (seed == 16'h0000) ? LFSR_INIT : seed;
            end else begin
                r_lfsr <= w_lfsr_adv;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode <= mode_rand;
                    end
                end
                S_INIT: begin
                    r_t <= identity_tiles();
                    r_i <= IW'(CELLS - 2);
                end
                S_SHUFFLE: begin
                    r_t <= w_t_swap;
                    r_i <= r_i - IW'(1);
                end
                S_FIX: begin
                    r_t     <= w_t_fix;
                    r_board <= layout(w_t_fix);
                end
                default: begin
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign board = r_board;

endmodule

// File: tb/tb_board_shuffler.sv
// Directed and randomized checks for board_shuffler at CELLS=4, CW=3, BLANK=3'b100, BLANK_POS=1.
// Expected boards follow BOARD_PARITY_FIX_EN when it is defined.
module tb_board_shuffler;

    localparam int unsigned CELLS = 4;
    localparam int unsigned CW    = 3;
    localparam logic [2:0]  BLK   = 3'b100;
    localparam int unsigned BPOS  = 1;

    logic        clk_d = 1'b0;
    logic        rst;
    logic        start;
    logic        mode_rand;
    logic        seed_load;
    logic [15:0] seed;
    logic        busy;
    logic        done;
    logic [11:0] board;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        mode;
        logic [15:0] seed;
        logic [11:0] exp_plain;
        logic [11:0] exp_fix;
        int          lat;
    } vec_t;

    vec_t vecs[5];

    board_shuffler #(
        .CELLS     (CELLS),
        .CW        (CW),
        .BLANK     (BLK),
        .BLANK_POS (BPOS)
    ) dut (
        .clk_d     (clk_d),
        .rst       (rst),
        .start     (start),
        .mode_rand (mode_rand),
        .seed_load (seed_load),
        .seed      (seed),
        .busy      (busy),
        .done      (done),
        .board     (board)
    );

    always #5 clk_d = ~clk_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_d);
        #1;
    endtask

    function automatic logic [11:0] exp_of(input vec_t v);
`ifdef BOARD_PARITY_FIX_EN
        return v.exp_fix;
`else
        return v.exp_plain;
`endif
    endfunction

    function automatic logic [15:0] adv(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    // Reference board for a random run whose seed was loaded the cycle before start.
    function automatic logic [11:0] model(input logic [15:0] s);
        logic [2:0]  t[3];
        logic [2:0]  tmp;
        logic [15:0] l;
        int          j;
        int          inv;
        for (int k = 0; k < 3; k++) t[k] = 3'(k);
        l = (s == 16'h0000) ? 16'hACE1 : s;
        l = adv(l);
        for (int i = 2; i >= 1; i--) begin
            l    = adv(l);
            j    = int'(l[7:0]) % (i + 1);
            tmp  = t[i];
            t[i] = t[j];
            t[j] = tmp;
        end
        inv = 0;
        for (int a = 0; a < 3; a++)
            for (int b = a + 1; b < 3; b++)
                if (t[a] > t[b]) inv++;
`ifdef BOARD_PARITY_FIX_EN
        if (inv % 2 == 1) begin
            tmp  = t[2];
            t[2] = t[1];
            t[1] = tmp;
        end
`endif
        return {t[2], t[1], BLK, t[0]};
    endfunction

    function automatic int inversions(input logic [11:0] b);
        logic [2:0] t[3];
        int         inv;
        t[0] = b[2:0];
        t[1] = b[8:6];
        t[2] = b[11:9];
        inv = 0;
        for (int a = 0; a < 3; a++)
            for (int c = a + 1; c < 3; c++)
                if (t[a] > t[c]) inv++;
        return inv;
    endfunction

    function automatic logic is_perm(input logic [11:0] b);
        logic [2:0] t[3];
        logic [7:0] mask;
        t[0] = b[2:0];
        t[1] = b[8:6];
        t[2] = b[11:9];
        mask = 8'h00;
        for (int k = 0; k < 3; k++) mask[t[k]] = 1'b1;
        return (mask == 8'h07) && (b[5:3] == BLK);
    endfunction

    task automatic run_vec(input int idx, input vec_t v, input logic [11:0] prev);
        logic [11:0] e;
        e         = exp_of(v);
        seed_load = 1'b1;
        seed      = v.seed;
        step();
        seed_load = 1'b0;
        start     = 1'b1;
        mode_rand = v.mode;
        chk($sformatf("v%0d busy_c0", idx), 32'(busy), 32'd0);
        step();
        start     = 1'b0;
        mode_rand = 1'b0;
        for (int c = 1; c <= v.lat; c++) begin
            chk($sformatf("v%0d busy_c%0d", idx, c), 32'(busy), 32'd1);
            chk($sformatf("v%0d done_c%0d", idx, c), 32'(done), 32'(c == v.lat));
            if (c < v.lat)
                chk($sformatf("v%0d board_hold_c%0d", idx, c), 32'(board), 32'(prev));
            else
                chk($sformatf("v%0d board", idx), 32'(board), 32'(e));
            step();
        end
        chk($sformatf("v%0d busy_after", idx), 32'(busy), 32'd0);
        chk($sformatf("v%0d done_after", idx), 32'(done), 32'd0);
        chk($sformatf("v%0d board_after", idx), 32'(board), 32'(e));
    endtask

    initial begin
        logic [11:0] cur;
        logic [15:0] s;
        logic [11:0] m;
        int          ndone;
        int          done_cyc;
        int          seen_odd;
        int          seen_even;

        vecs[0] = '{1'b0, 16'h0000, 12'h460, 12'h460, 3};
        vecs[1] = '{1'b1, 16'h0000, 12'h421, 12'h0A1, 5};
        vecs[2] = '{1'b1, 16'h0001, 12'h0A1, 12'h0A1, 5};
        vecs[3] = '{1'b1, 16'h00FF, 12'h062, 12'h222, 5};
        vecs[4] = '{1'b0, 16'h1234, 12'h460, 12'h460, 3};

        rst       = 1'b1;
        start     = 1'b0;
        mode_rand = 1'b0;
        seed_load = 1'b0;
        seed      = 16'h0000;
        step();
        step();
        chk("reset board", 32'(board), 32'h924);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        rst = 1'b0;
        step();
        chk("post-reset board", 32'(board), 32'h924);

        cur = 12'h924;
        for (int v = 0; v < 5; v++) begin
            run_vec(v, vecs[v], cur);
            cur = exp_of(vecs[v]);
        end

        // Start pulses while busy must be dropped.
        start     = 1'b1;
        mode_rand = 1'b0;
        step();
        ndone    = 0;
        done_cyc = -1;
        for (int c = 1; c <= 12; c++) begin
            if (done) begin
                ndone++;
                done_cyc = c;
            end
            start = (c <= 3) ? 1'b1 : 1'b0;
            step();
        end
        chk("ignore_start done_count", 32'(ndone), 32'd1);
        chk("ignore_start done_cycle", 32'(done_cyc), 32'd3);
        chk("ignore_start busy_end", 32'(busy), 32'd0);

        // Abort a random run at cycle 3.
        seed_load = 1'b1;
        seed      = 16'h0000;
        step();
        seed_load = 1'b0;
        start     = 1'b1;
        mode_rand = 1'b1;
        step();
        start     = 1'b0;
        mode_rand = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("abort board", 32'(board), 32'h924);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        step();
        rst   = 1'b0;
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) ndone++;
            step();
        end
        chk("abort no_done", 32'(ndone), 32'd0);
        chk("abort board_idle", 32'(board), 32'h924);
        run_vec(10, vecs[0], 12'h924);
        run_vec(11, vecs[1], exp_of(vecs[0]));

        // Randomized runs against the reference model.
        seen_odd  = 0;
        seen_even = 0;
        for (int n = 0; n < 1000; n++) begin
            s         = 16'($urandom);
            m         = model(s);
            seed_load = 1'b1;
            seed      = s;
            step();
            seed_load = 1'b0;
            start     = 1'b1;
            mode_rand = 1'b1;
            step();
            start     = 1'b0;
            mode_rand = 1'b0;
            for (int c = 1; c < 5; c++) step();
            chk($sformatf("rand%0d done seed=%0h", n, s), 32'(done), 32'd1);
            chk($sformatf("rand%0d board seed=%0h", n, s), 32'(board), 32'(m));
            chk($sformatf("rand%0d perm", n), 32'(is_perm(board)), 32'd1);
            if (inversions(board) % 2 == 1) seen_odd = 1;
            else seen_even = 1;
`ifdef BOARD_PARITY_FIX_EN
            chk($sformatf("rand%0d parity", n), 32'(inversions(board) % 2), 32'd0);
`endif
            step();
        end
`ifndef BOARD_PARITY_FIX_EN
        chk("both parities seen", 32'(seen_odd + seen_even), 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
